// File: rtl/vram_scroller_pkg.sv
// Shared definitions for the text-VRAM scroll engine: FSM states and scroll
// direction codes.
package vram_scroller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_FILL  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/vram_scroller_row_sel.sv
// Combinational row selector: maps the current destination row to its source
// row, decides fill vs copy, and steps to the next destination row.
module vram_scroller_row_sel
  import vram_scroller_pkg::*;
#(
  parameter int ROW_W = 5
) (
  input  logic             dir,
  input  logic [ROW_W-1:0] dst,
  input  logic [ROW_W:0]   n,
  input  logic [ROW_W-1:0] first,
  input  logic [ROW_W-1:0] last,
  output logic [ROW_W-1:0] src,
  output logic             fill_flag,
  output logic [ROW_W-1:0] next_dst,
  output logic             next_fill_flag,
  output logic             last_row_flag
);

  localparam logic [ROW_W-1:0] ROW_ONE   = {{(ROW_W-1){1'b0}}, 1'b1};
  localparam logic [ROW_W:0]   ROW_ONE_X = {{ROW_W{1'b0}}, 1'b1};

  logic [ROW_W:0] dst_x_s;
  logic [ROW_W:0] first_x_s;
  logic [ROW_W:0] last_x_s;
  logic [ROW_W:0] src_x_s;
  logic [ROW_W:0] nxt_src_x_s;

  // Extra top bit keeps over/underflowed sources out of the valid row range.
  always_comb begin
    dst_x_s     = {1'b0, dst};
    first_x_s   = {1'b0, first};
    last_x_s    = {1'b0, last};
    src_x_s     = {(ROW_W+1){1'b0}};
    nxt_src_x_s = {(ROW_W+1){1'b0}};
    if (dir == DIR_UP) begin
      src_x_s        = dst_x_s + n;
      nxt_src_x_s    = dst_x_s + ROW_ONE_X + n;
      fill_flag      = (src_x_s > last_x_s);
      next_fill_flag = (nxt_src_x_s > last_x_s);
      next_dst       = dst + ROW_ONE;
      last_row_flag  = (dst == last);
    end else begin
      src_x_s        = dst_x_s - n;
      nxt_src_x_s    = dst_x_s - ROW_ONE_X - n;
      fill_flag      = src_x_s[ROW_W] | (src_x_s < first_x_s);
      next_fill_flag = nxt_src_x_s[ROW_W] | (nxt_src_x_s < first_x_s);
      next_dst       = dst - ROW_ONE;
      last_row_flag  = (dst == first);
    end
    src = src_x_s[ROW_W-1:0];
  end

endmodule

// File: rtl/vram_scroller.sv
// Text-VRAM scroll engine: moves a row window up or down by N lines through a
// single-port VRAM, filling vacated rows with a latched character.
module vram_scroller
  import vram_scroller_pkg::*;
#(
  parameter int ROW_W  = 5,
  parameter int COL_W  = 6,
  parameter int COLS   = 60,
  parameter int DATA_W = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_dir,
  input  logic [ROW_W-1:0]       i_lines,
  input  logic [ROW_W-1:0]       i_first_row,
  input  logic [ROW_W-1:0]       i_last_row,
  input  logic [DATA_W-1:0]      i_fill,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [ROW_W+COL_W-1:0] o_vram_addr,
  output logic [DATA_W-1:0]      o_vram_din,
  input  logic [DATA_W-1:0]      i_vram_dout,
  output logic                   o_vram_ce,
  output logic                   o_vram_wre
);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
  localparam logic [COL_W-1:0] COL_ONE   = {{(COL_W-1){1'b0}}, 1'b1};
  localparam logic [ROW_W:0]   ROW_ONE_X = {{ROW_W{1'b0}}, 1'b1};

  state_t              state_r;
  state_t              state_n;
  logic                dir_r;
  logic [ROW_W:0]      n_r;
  logic [ROW_W-1:0]    first_r;
  logic [ROW_W-1:0]    last_r;
  logic [DATA_W-1:0]   fill_r;
  logic [ROW_W-1:0]    dst_r;
  logic [COL_W-1:0]    col_r;

  logic [ROW_W:0]      first_x_s;
  logic [ROW_W:0]      last_x_s;
  logic [ROW_W:0]      lines_x_s;
  logic [ROW_W:0]      h_s;
  logic [ROW_W:0]      n_s;
  logic                bad_s;
  logic                start_fill_s;

  logic [ROW_W-1:0]    src_s;
  logic                cur_fill_s;
  logic [ROW_W-1:0]    nxt_dst_s;
  logic                nxt_fill_s;
  logic                cur_last_s;
  logic                col_wrap_s;

  vram_scroller_row_sel #(.ROW_W(ROW_W)) u_row_sel (
    .dir            (dir_r),
    .dst            (dst_r),
    .n              (n_r),
    .first          (first_r),
    .last           (last_r),
    .src            (src_s),
    .fill_flag      (cur_fill_s),
    .next_dst       (nxt_dst_s),
    .next_fill_flag (nxt_fill_s),
    .last_row_flag  (cur_last_s)
  );

  // Window height and clamped line count from the request; the first row is
  // pure fill exactly when the clamped count covers the whole window.
  always_comb begin
    first_x_s    = {1'b0, i_first_row};
    last_x_s     = {1'b0, i_last_row};
    lines_x_s    = {1'b0, i_lines};
    h_s          = last_x_s - first_x_s + ROW_ONE_X;
    bad_s        = (i_first_row > i_last_row) || (i_lines == {ROW_W{1'b0}});
    if (lines_x_s < h_s) begin
      n_s = lines_x_s;
    end else begin
      n_s = h_s;
    end
    start_fill_s = (lines_x_s >= h_s);
  end

  // Next-state logic.
  always_comb begin
    state_n    = state_r;
    col_wrap_s = (col_r == COL_LAST);
    case (state_r)
      ST_IDLE: begin
        if (!i_start) begin
          state_n = ST_IDLE;
        end else if (bad_s) begin
          state_n = ST_DONE;
        end else if (start_fill_s) begin
          state_n = ST_FILL;
        end else begin
          state_n = ST_READ;
        end
      end
      ST_READ: state_n = ST_WRITE;
      ST_WRITE, ST_FILL: begin
        if (!col_wrap_s) begin
          state_n = cur_fill_s ? ST_FILL : ST_READ;
        end else if (cur_last_s) begin
          state_n = ST_DONE;
        end else begin
          state_n = nxt_fill_s ? ST_FILL : ST_READ;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // State, latched operands and cell cursor.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
      dir_r   <= DIR_UP;
      n_r     <= {(ROW_W+1){1'b0}};
      first_r <= {ROW_W{1'b0}};
      last_r  <= {ROW_W{1'b0}};
      fill_r  <= {DATA_W{1'b0}};
      dst_r   <= {ROW_W{1'b0}};
      col_r   <= {COL_W{1'b0}};
    end else begin
      state_r <= state_n;
      case (state_r)
        ST_IDLE: begin
          if (i_start) begin
            dir_r   <= i_dir;
            n_r     <= n_s;
            first_r <= i_first_row;
            last_r  <= i_last_row;
            fill_r  <= i_fill;
            dst_r   <= (i_dir == DIR_UP) ? i_first_row : i_last_row;
            col_r   <= {COL_W{1'b0}};
          end
        end
        ST_WRITE, ST_FILL: begin
          if (col_wrap_s) begin
            col_r <= {COL_W{1'b0}};
            dst_r <= nxt_dst_s;
          end else begin
            col_r <= col_r + COL_ONE;
          end
        end
        default: begin
          col_r <= col_r;
        end
      endcase
    end
  end

  // VRAM port and status decode from the registered state.
  always_comb begin
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_vram_ce   = 1'b0;
    o_vram_wre  = 1'b0;
    o_vram_addr = {(ROW_W+COL_W){1'b0}};
    o_vram_din  = {DATA_W{1'b0}};
    case (state_r)
      ST_READ: begin
        o_busy      = 1'b1;
        o_vram_ce   = 1'b1;
        o_vram_addr = {src_s, col_r};
      end
      ST_WRITE: begin
        o_busy      = 1'b1;
        o_vram_ce   = 1'b1;
        o_vram_wre  = 1'b1;
        o_vram_addr = {dst_r, col_r};
        o_vram_din  = i_vram_dout;
      end
      ST_FILL: begin
        o_busy      = 1'b1;
        o_vram_ce   = 1'b1;
        o_vram_wre  = 1'b1;
        o_vram_addr = {dst_r, col_r};
        o_vram_din  = fill_r;
      end
      ST_DONE: o_done = 1'b1;
      default: o_done = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_vram_scroller.sv
// Scoreboard bench for vram_scroller: VRAM model with 1-cycle read latency and
// a row-shift reference of the expected memory image after every operation.
module tb_vram_scroller;

  localparam int ROW_W  = 5;
  localparam int COL_W  = 6;
  localparam int COLS   = 60;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << (ROW_W + COL_W);

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic                   dir;
  logic [ROW_W-1:0]       lines;
  logic [ROW_W-1:0]       first_row;
  logic [ROW_W-1:0]       last_row;
  logic [DATA_W-1:0]      fill;
  logic                   busy;
  logic                   done;
  logic [ROW_W+COL_W-1:0] vram_addr;
  logic [DATA_W-1:0]      vram_din;
  logic [DATA_W-1:0]      vram_dout;
  logic                   vram_ce;
  logic                   vram_wre;

  always #5 clk = ~clk;

  vram_scroller #(.ROW_W(ROW_W), .COL_W(COL_W), .COLS(COLS), .DATA_W(DATA_W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_dir       (dir),
    .i_lines     (lines),
    .i_first_row (first_row),
    .i_last_row  (last_row),
    .i_fill      (fill),
    .o_busy      (busy),
    .o_done      (done),
    .o_vram_addr (vram_addr),
    .o_vram_din  (vram_din),
    .i_vram_dout (vram_dout),
    .o_vram_ce   (vram_ce),
    .o_vram_wre  (vram_wre)
  );

  typedef struct {
    logic             dir;
    int               lines;
    int               first;
    int               last;
    logic [DATA_W-1:0] fill;
    int               busy;
    int               reads;
    int               writes;
    int               idle;
  } exp_t;

  exp_t sb_q[$];

  logic [DATA_W-1:0] mem     [0:DEPTH-1];
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  logic              mem_init_done = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int idle_cnt = 0;
  int oob_cnt  = 0;
  int proto_cnt = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic exp_t make_exp(input logic d, input int ln, input int f, input int l,
                                    input logic [DATA_W-1:0] fl, input int idl);
    exp_t e;
    int h;
    int n;
    e.dir = d; e.lines = ln; e.first = f; e.last = l; e.fill = fl; e.idle = idl;
    if (f > l || ln == 0) begin
      e.busy = 0; e.reads = 0; e.writes = 0;
    end else begin
      h = l - f + 1;
      n = (ln < h) ? ln : h;
      e.busy   = 2 * COLS * (h - n) + COLS * n;
      e.reads  = COLS * (h - n);
      e.writes = COLS * h;
    end
    return e;
  endfunction

  task automatic apply_ref(input exp_t e);
    int h;
    int n;
    if (e.first > e.last || e.lines == 0) return;
    h = e.last - e.first + 1;
    n = (e.lines < h) ? e.lines : h;
    if (e.dir == 1'b0) begin
      for (int d = e.first; d <= e.last; d++)
        for (int c = 0; c < COLS; c++)
          ref_mem[d * (1 << COL_W) + c] = (d + n <= e.last) ? ref_mem[(d + n) * (1 << COL_W) + c] : e.fill;
    end else begin
      for (int d = e.last; d >= e.first; d--)
        for (int c = 0; c < COLS; c++)
          ref_mem[d * (1 << COL_W) + c] = (d - n >= e.first) ? ref_mem[(d - n) * (1 << COL_W) + c] : e.fill;
    end
  endtask

  // VRAM model: random initial image, synchronous write, 1-cycle read latency.
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'($urandom);
      mem_init_done <= 1'b1;
    end else if (vram_ce) begin
      if (vram_wre) mem[vram_addr] <= vram_din;
      else          vram_dout      <= mem[vram_addr];
    end
  end

  // Monitor: counts port activity and scores each operation at its done pulse.
  always @(negedge clk) begin
    int row;
    int mism;
    exp_t e;
    if (!rst_n) begin
      busy_cnt = 0; rd_cnt = 0; wr_cnt = 0; idle_cnt = 0; oob_cnt = 0; proto_cnt = 0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem[i];
    end else begin
      row = int'(vram_addr[ROW_W+COL_W-1:COL_W]);
      if (busy) busy_cnt++;
      if (vram_ce && !vram_wre) rd_cnt++;
      if (vram_ce && vram_wre) wr_cnt++;
      if (vram_wre && !vram_ce) proto_cnt++;
      if (vram_ce && !busy) proto_cnt++;
      if (busy && done) proto_cnt++;
      if (vram_ce) begin
        if (sb_q.size() == 0) oob_cnt++;
        else if (row < sb_q[0].first || row > sb_q[0].last) oob_cnt++;
      end
      if (!busy && !done) idle_cnt++;
      if (done) begin
        done_cnt++;
        check_eq("sb_nonempty", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check_eq("busy_cycles", busy_cnt, e.busy);
          check_eq("read_cycles", rd_cnt, e.reads);
          check_eq("write_cycles", wr_cnt, e.writes);
          check_eq("out_of_window_ce", oob_cnt, 0);
          check_eq("protocol", proto_cnt, 0);
          if (e.idle >= 0) check_eq("b2b_idle_gap", idle_cnt, e.idle);
          apply_ref(e);
          mism = 0;
          for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) mism++;
          check_eq("vram_image", mism, 0);
        end
        busy_cnt = 0; rd_cnt = 0; wr_cnt = 0; idle_cnt = 0; oob_cnt = 0; proto_cnt = 0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      step();
      k++;
    end
    check_eq("done_timeout", int'(done_cnt >= target), 1);
  endtask

  task automatic start_op(input logic d, input int ln, input int f, input int l,
                          input logic [DATA_W-1:0] fl);
    dir = d; lines = ROW_W'(ln); first_row = ROW_W'(f); last_row = ROW_W'(l); fill = fl;
    start = 1'b1;
    sb_q.push_back(make_exp(d, ln, f, l, fl, -1));
    step();
    start = 1'b0;
    dir = 1'($urandom); lines = ROW_W'($urandom); first_row = ROW_W'($urandom);
    last_row = ROW_W'($urandom); fill = DATA_W'($urandom);
  endtask

  task automatic run_op(input logic d, input int ln, input int f, input int l,
                        input logic [DATA_W-1:0] fl);
    int tgt;
    tgt = done_cnt + 1;
    start_op(d, ln, f, l, fl);
    wait_done(tgt, 5000);
    step();
  endtask

  initial begin
    int tgt;
    int ce_seen;
    rst_n = 1'b0; start = 1'b0; dir = 1'b0; lines = '0; first_row = '0; last_row = '0; fill = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_ce", int'(vram_ce), 0);
    check_eq("rst_wre", int'(vram_wre), 0);
    check_eq("rst_addr", int'(vram_addr), 0);
    check_eq("rst_din", int'(vram_din), 0);
    step();
    rst_n = 1'b1;
    step();

    run_op(1'b0, 1, 0, 16, 8'h20);
    run_op(1'b1, 2, 3, 8, 8'h2E);
    run_op(1'b0, 20, 0, 16, 8'h41);
    run_op(1'b0, 0, 2, 9, 8'h42);
    run_op(1'b1, 3, 10, 5, 8'h43);
    run_op(1'b1, 5, 0, 31, 8'h44);

    // Start pulse while busy must be dropped.
    tgt = done_cnt + 1;
    start_op(1'b1, 1, 2, 6, 8'h2A);
    repeat (50) step();
    dir = 1'b0; lines = 5'd3; first_row = 5'd0; last_row = 5'd30; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(tgt, 5000);
    repeat (10) step();
    check_eq("midop_single_done", done_cnt, tgt);
    check_eq("midop_no_restart", busy_cnt, 0);

    // Reset in the middle of an operation.
    tgt = done_cnt;
    start_op(1'b0, 1, 0, 16, 8'h20);
    repeat (499) step();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midrst_busy", int'(busy), 0);
    check_eq("midrst_ce", int'(vram_ce), 0);
    check_eq("midrst_done", int'(done), 0);
    sb_q.delete();
    step();
    rst_n = 1'b1;
    ce_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (vram_ce || done) ce_seen++;
    end
    check_eq("midrst_quiet", ce_seen, 0);
    check_eq("midrst_no_done", done_cnt, tgt);
    run_op(1'b0, 1, 0, 16, 8'h20);

    // Back-to-back with start held high.
    tgt = done_cnt + 3;
    dir = 1'b0; lines = 5'd1; first_row = 5'd20; last_row = 5'd23; fill = 8'h23;
    start = 1'b1;
    sb_q.push_back(make_exp(1'b0, 1, 20, 23, 8'h23, -1));
    sb_q.push_back(make_exp(1'b0, 1, 20, 23, 8'h23, 1));
    sb_q.push_back(make_exp(1'b0, 1, 20, 23, 8'h23, 1));
    wait_done(tgt, 3000);
    start = 1'b0;
    repeat (8) step();
    check_eq("b2b_done_count", done_cnt, tgt);
    check_eq("b2b_stopped", busy_cnt, 0);

    for (int k = 0; k < 4; k++) begin
      run_op(1'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 31)), DATA_W'($urandom));
    end

    check_eq("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
